// File: rtl/alu_muldiv_pkg.sv
// Shared CPU definitions for the M-extension execute unit: RV32M funct3
// codes, R-type opcode/funct7 and the multi-cycle unit's state encoding.
package cpu_defs;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] FUNCT7_M_EXT  = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/alu_muldiv_div_core.sv
// Iterative magnitude datapath: radix-2 restoring divide, or shift-add
// multiply when mode_mul is set. One bit per step; {acc, low} holds the result.
module div_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            mode_mul,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] acc,
    output logic [XLEN-1:0] low
);

    logic [XLEN-1:0] acc_q, low_q, oper_q;
    logic [XLEN:0]   shifted, diff, sum;

    always_comb begin
        shifted = {acc_q, low_q[XLEN-1]};
        diff    = shifted - {1'b0, oper_q};
        sum     = {1'b0, acc_q} + {1'b0, oper_q};
    end

    // Divide: acc = partial remainder, low shifts dividend out / quotient in.
    // Multiply: acc = running high half, low shifts multiplier out / product in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            low_q  <= '0;
            oper_q <= '0;
        end else if (load) begin
            acc_q  <= '0;
            low_q  <= a;
            oper_q <= b;
        end else if (step) begin
            if (mode_mul) begin
                if (low_q[0]) {acc_q, low_q} <= {sum, low_q[XLEN-1:1]};
                else          {acc_q, low_q} <= {1'b0, acc_q, low_q[XLEN-1:1]};
            end else if (!diff[XLEN]) begin
                acc_q <= diff[XLEN-1:0];
                low_q <= {low_q[XLEN-2:0], 1'b1};
            end else begin
                acc_q <= shifted[XLEN-1:0];
                low_q <= {low_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        acc = acc_q;
        low = low_q;
    end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M execute unit: all MUL*/DIV*/REM* ops, stalls the pipeline
// via busy_o and returns one result with its rd on a single done_o pulse.
module alu_muldiv
    import cpu_defs::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_ITER   = 0,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       op1_i,
    input  logic [XLEN-1:0]       op2_i,
    input  logic [REG_ADDR_W-1:0] wr_reg_addr_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       result_o,
    output logic [REG_ADDR_W-1:0] wr_reg_addr_o
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    md_state_e             state_q, state_d;
    logic [2:0]            op_q;
    logic                  neg_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       result_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  signed1, signed2, sign1, sign2, neg_start;
    logic [XLEN-1:0]       mag1, mag2, fast_result;
    logic                  div_zero, overflow, fast, accept;
    logic [2*XLEN-1:0]     comb_prod;
    logic [XLEN-1:0]       core_acc, core_low;

    // Sign-correct a magnitude result; hi/lo are remainder/quotient for divides.
    function automatic logic [XLEN-1:0] finish(input logic [2:0] op, input logic neg,
                                               input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] p;
        if (op[2]) begin
            if (op[1]) return neg ? -hi : hi;
            return neg ? -lo : lo;
        end
        p = neg ? -{hi, lo} : {hi, lo};
        return (op == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    always_comb begin
        signed1   = op_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        signed2   = op_i inside {F3_MULH, F3_DIV, F3_REM};
        sign1     = signed1 & op1_i[XLEN-1];
        sign2     = signed2 & op2_i[XLEN-1];
        mag1      = sign1 ? -op1_i : op1_i;
        mag2      = sign2 ? -op2_i : op2_i;
        neg_start = (op_i[2] && op_i[1]) ? sign1 : (sign1 ^ sign2);
        div_zero  = op_i[2] && (op2_i == '0);
        overflow  = (op_i == F3_DIV || op_i == F3_REM) &&
                    (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
        fast      = div_zero || overflow || (!op_i[2] && MUL_ITER == 0);
        accept    = start_i && !flush_i;
    end

    generate
        if (MUL_ITER == 0) begin : g_comb_mul
            always_comb comb_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        end else begin : g_iter_mul
            always_comb comb_prod = '0;
        end
    endgenerate

    always_comb begin
        if (div_zero)      fast_result = op_i[1] ? op1_i : '1;
        else if (overflow) fast_result = op_i[1] ? '0 : op1_i;
        else               fast_result = finish(op_i, neg_start,
                                                comb_prod[2*XLEN-1:XLEN],
                                                comb_prod[XLEN-1:0]);
    end

    div_core #(.XLEN(XLEN)) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ST_IDLE && accept && !fast),
        .step     (state_q == ST_CALC),
        .mode_mul (!op_q[2]),
        .a        (mag1),
        .b        (mag2),
        .acc      (core_acc),
        .low      (core_low)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = fast ? ST_DONE : ST_CALC;
            ST_CALC: if (flush_i) state_d = ST_IDLE;
                     else if (cnt_q == '0) state_d = ST_FIX;
            ST_FIX:  state_d = flush_i ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && accept) begin
                op_q  <= op_i;
                neg_q <= neg_start;
                rd_q  <= wr_reg_addr_i;
                cnt_q <= CNT_W'(XLEN - 1);
                if (fast) result_q <= fast_result;
            end
            if (state_q == ST_CALC) cnt_q <= cnt_q - CNT_W'(1);
            if (state_q == ST_FIX) result_q <= finish(op_q, neg_q, core_acc, core_low);
        end
    end

    // A flush landing on the DONE cycle still kills the result.
    always_comb begin
        busy_o        = (state_q == ST_CALC) || (state_q == ST_FIX);
        done_o        = (state_q == ST_DONE) && !flush_i;
        result_o      = done_o ? result_q : '0;
        wr_reg_addr_o = done_o ? rd_q : '0;
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: one combinational-multiply and one
// shift-add-multiply instance share stimulus; monitors check every done pulse.
module tb_alu_muldiv;
    import cpu_defs::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          start;
        int          lat;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, flush_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] op1_i = '0, op2_i = '0;
    logic [4:0]  rd_i = '0;
    logic        busy0, done0, busy1, done1;
    logic [31:0] res0, res1;
    logic [4:0]  rdo0, rdo1;

    int   tests = 0, fails = 0, cyc = 0;
    exp_t q0[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_muldiv #(.XLEN(32), .MUL_ITER(0), .REG_ADDR_W(5)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .op1_i(op1_i),
        .op2_i(op2_i), .wr_reg_addr_i(rd_i), .flush_i(flush_i), .busy_o(busy0),
        .done_o(done0), .result_o(res0), .wr_reg_addr_o(rdo0)
    );

    alu_muldiv #(.XLEN(32), .MUL_ITER(1), .REG_ADDR_W(5)) u_dut_iter (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .op1_i(op1_i),
        .op2_i(op2_i), .wr_reg_addr_i(rd_i), .flush_i(flush_i), .busy_o(busy1),
        .done_o(done1), .result_o(res1), .wr_reg_addr_o(rdo1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_out(input int idx, input logic done, input logic [31:0] res,
                             input logic [4:0] rd);
        exp_t e;
        if (!done) begin
            check($sformatf("idle_result%0d", idx), res, 32'h0);
            return;
        end
        if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done%0d: got result 0x%08h, expected no done", idx, res);
            return;
        end
        if (idx == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        check($sformatf("result%0d", idx), res, e.res);
        check($sformatf("rd%0d", idx), {27'd0, rd}, {27'd0, e.rd});
        check($sformatf("latency%0d", idx), 32'(cyc - e.start + 1), 32'(e.lat));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_out(0, done0, res0, rdo0);
            check_out(1, done1, res1, rdo1);
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++)
            @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d/%0d pending results, expected 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    // fast marks divide-by-zero / signed-overflow vectors; MULs are fast only on u_dut.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit fast,
                         input bit push);
        exp_t e;
        wait_idle();
        start_i = 1'b1;
        op_i    = op;
        op1_i   = a;
        op2_i   = b;
        rd_i    = rd;
        if (push) begin
            e.res   = exp;
            e.rd    = rd;
            e.start = cyc + 1;
            e.lat   = (fast || !op[2]) ? 1 : 34;
            q0.push_back(e);
            e.lat   = fast ? 1 : 34;
            q1.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_busy0", {31'd0, busy0}, 32'h0);
        check("rst_done0", {31'd0, done0}, 32'h0);
        check("rst_result0", res0, 32'h0);
        check("rst_rd1", {27'd0, rdo1}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        issue(F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 0, 1);
        issue(F3_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 0, 1);
        issue(F3_DIVU,   32'd100,      32'd0,        5'd7,  32'hFFFFFFFF, 1, 1);
        issue(F3_REMU,   32'd100,      32'd0,        5'd8,  32'd100,      1, 1);
        issue(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000, 1, 1);
        issue(F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h0,        1, 1);
        issue(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h0,        0, 1);
        issue(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFE, 0, 1);
        issue(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFF, 0, 1);
        issue(F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'h00000001, 0, 1);
        issue(F3_DIV,    32'd20,       32'hFFFFFFFD, 5'd15, 32'hFFFFFFFA, 0, 1);
        issue(F3_REM,    32'd20,       32'hFFFFFFFD, 5'd16, 32'd2,        0, 1);
        issue(F3_DIVU,   32'hFFFFFFFF, 32'd16,       5'd17, 32'h0FFFFFFF, 0, 1);
        issue(F3_REMU,   32'hFFFFFFFF, 32'd16,       5'd18, 32'h0000000F, 0, 1);
        issue(F3_DIV,    32'hFFFFFFFB, 32'd0,        5'd19, 32'hFFFFFFFF, 1, 1);
        issue(F3_REM,    32'hFFFFFFFB, 32'd0,        5'd0,  32'hFFFFFFFB, 1, 1);
        issue(F3_MULH,   32'hFFFFFFFE, 32'd3,        5'd20, 32'hFFFFFFFF, 0, 1);
        issue(F3_MUL,    32'hFFFFFFFE, 32'd3,        5'd21, 32'hFFFFFFFA, 0, 1);
        issue(F3_MULHU,  32'h00010000, 32'h00010000, 5'd22, 32'h00000001, 0, 1);
        issue(F3_MULHSU, 32'd2,        32'hFFFFFFFF, 5'd23, 32'h00000001, 0, 1);
        issue(F3_MULH,   32'd2,        32'hFFFFFFFF, 5'd24, 32'hFFFFFFFF, 0, 1);

        // Flush mid-CALC, then a fresh divide completes normally.
        issue(F3_DIVU, 32'd1000, 32'd7, 5'd25, 32'd142, 0, 0);
        repeat (8) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_calc_busy0", {31'd0, busy0}, 32'h0);
        check("flush_calc_busy1", {31'd0, busy1}, 32'h0);
        issue(F3_DIVU, 32'd9, 32'd3, 5'd26, 32'd3, 0, 1);

        // Flush during FIX: 32 CALC edges after the start edge lands in FIX.
        issue(F3_DIVU, 32'd77, 32'd7, 5'd27, 32'd11, 0, 0);
        repeat (32) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_fix_busy0", {31'd0, busy0}, 32'h0);
        repeat (3) @(negedge clk);

        // Start and flush together in IDLE: the start is dropped.
        wait_idle();
        start_i = 1'b1; flush_i = 1'b1; op_i = F3_DIVU; op1_i = 32'd5; op2_i = 32'd0; rd_i = 5'd28;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        check("start_flush_busy1", {31'd0, busy1}, 32'h0);
        repeat (3) @(negedge clk);

        // Start while busy is ignored; the original result and rd stand.
        issue(F3_DIVU, 32'd50, 32'd5, 5'd9, 32'd10, 0, 1);
        repeat (5) @(negedge clk);
        start_i = 1'b1; op_i = F3_MUL; op1_i = 32'd3; op2_i = 32'd4; rd_i = 5'd7;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_hold0", {31'd0, busy0}, 32'h1);

        // Asynchronous reset mid-CALC, between clock edges.
        issue(F3_DIV, 32'd100, 32'd3, 5'd4, 32'd33, 0, 0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_busy0", {31'd0, busy0}, 32'h0);
        check("async_busy1", {31'd0, busy1}, 32'h0);
        check("async_done0", {31'd0, done0}, 32'h0);
        check("async_result1", res1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        issue(F3_DIV, 32'd100, 32'd3, 5'd4, 32'd33, 0, 1);

        wait_idle();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
